// File: rtl/snoopy_bus_arbiter.sv
// snoopy_bus_arbiter: round-robin bus arbiter for snooping caches.
// A grant is held for as long as the owner keeps requesting. When the owner
// releases, the next requester takes the bus on the following edge with no
// idle cycle in between. Every output comes straight from a register.
// Optional watchdog: define SNOOPY_ARBITER_WATCHDOG_EN to build it in. The
// watchdog takes the bus away from an owner that has held it for
// MAX_HOLD_CYCLES while another cache is waiting.
module snoopy_bus_arbiter #(
  parameter int NUMBER_OF_CACHES   = 4,
  parameter int CACHE_NUMBER_WIDTH = $clog2(NUMBER_OF_CACHES),
  parameter int MAX_HOLD_CYCLES    = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUMBER_OF_CACHES-1:0]   request,
  output logic [NUMBER_OF_CACHES-1:0]   grant,
  output logic [CACHE_NUMBER_WIDTH-1:0] ownerIndex,
  output logic                          busy,
  output logic                          timeout
);
  localparam int N = NUMBER_OF_CACHES;
  localparam int W = CACHE_NUMBER_WIDTH;

`ifdef SNOOPY_ARBITER_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE, GRANTED, REVOKE} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANTED} state_t;
`endif

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [W-1:0]   owner_q, owner_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic           busy_q, busy_d;
  logic           timeout_q, timeout_d;
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
  logic [7:0]     hold_q, hold_d;
`endif

  // Find the first set bit at or above start, wrapping around.
  // Returns {found, index}.
  function automatic logic [W:0] pick(input logic [N-1:0] req, input logic [W-1:0] start);
    logic [W:0]   res;
    logic [W-1:0] idx;
    int           j;
    res = '0;
    // Walk downward so that the lowest offset from start is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      idx = W'(j);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [W:0]   idle_win;   // winner searched from the stored pointer
  logic [W:0]   rel_win;    // winner searched from the slot after the releasing owner
  logic [W-1:0] nxt_owner;  // (owner + 1) mod N
  logic [N-1:0] others;     // requests from every cache except the owner

  // Winner candidates. On a release the search must use the updated pointer
  // and must skip the cache that is letting go of the bus.
  always_comb begin
    nxt_owner = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;
    others    = request & ~grant_q;
    idle_win  = pick(request, ptr_q);
    rel_win   = pick(others, nxt_owner);
  end

  // Next-state logic and registered outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      GRANTED: begin
        if (request[owner_q]) begin
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
          if (hold_q == 8'(MAX_HOLD_CYCLES) && |others) begin
            state_d   = REVOKE;
            grant_d   = '0;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
            ptr_d     = nxt_owner;
            hold_d    = '0;
          end else if (hold_q != 8'(MAX_HOLD_CYCLES)) begin
            hold_d = hold_q + 8'd1;
          end
`endif
        end else begin
          ptr_d = nxt_owner;
          if (rel_win[W]) begin
            grant_d            = '0;
            grant_d[rel_win[W-1:0]] = 1'b1;
            owner_d            = rel_win[W-1:0];
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
            hold_d             = '0;
`endif
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end
      end
      // IDLE, and REVOKE when the watchdog is built in, arbitrate from the pointer.
      default: begin
        if (idle_win[W]) begin
          state_d                  = GRANTED;
          grant_d                  = '0;
          grant_d[idle_win[W-1:0]] = 1'b1;
          owner_d                  = idle_win[W-1:0];
          busy_d                   = 1'b1;
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
          hold_d                   = '0;
`endif
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign ownerIndex = owner_q;
  assign busy       = busy_q;
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Testbench for snoopy_bus_arbiter: directed scenarios followed by random
// requests, checked against an integer-level round-robin reference model.
module tb_snoopy_bus_arbiter;
  localparam int N    = 4;
  localparam int W    = 2;
  localparam int MAXH = 4;
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] request = '0;
  logic [N-1:0] grant;
  logic [W-1:0] ownerIndex;
  logic         busy;
  logic         timeout;

  snoopy_bus_arbiter #(
    .NUMBER_OF_CACHES(N), .CACHE_NUMBER_WIDTH(W), .MAX_HOLD_CYCLES(MAXH)
  ) dut (
    .clock(clock), .reset(reset), .request(request),
    .grant(grant), .ownerIndex(ownerIndex), .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the owner as an integer (-1 means nobody holds the bus),
  // the round-robin start slot, and the number of cycles the owner has held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  function automatic int search(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input bit rst, input logic [N-1:0] r);
    logic [N-1:0] rest;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_owner < 0) begin
      m_owner = search(r, m_ptr);
      m_held  = 0;
    end else if (r[m_owner]) begin
      rest = r;
      rest[m_owner] = 1'b0;
      if (WD && m_held >= MAXH && rest != '0) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_to    = 1'b1;
        m_held  = 0;
      end else if (m_held < MAXH) begin
        m_held++;
      end
    end else begin
      m_ptr   = (m_owner + 1) % N;
      rest    = r;
      rest[m_owner] = 1'b0;
      m_owner = search(rest, m_ptr);
      m_held  = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("onehot", 32'($countones(grant) <= 1), 32'd1);
    if (m_owner >= 0) chk("ownerIndex", 32'(ownerIndex), 32'(m_owner));
  endtask

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, and sample the DUT 1 time unit later.
  task automatic step(input bit rst, input logic [N-1:0] r);
    @(negedge clock);
    reset   = rst;
    request = r;
    @(posedge clock);
    model_step(rst, r);
    #1;
    check_model();
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] prev;
    logic [N-1:0] eg;
    bit           rst;

    // Reset state
    step(1'b1, '0);
    step(1'b1, '0);
    chk("rst_ownerIndex", 32'(ownerIndex), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);

    // First grant from pointer 0
    step(1'b0, 4'b0101);
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_owner", 32'(ownerIndex), 32'd0);
    chk("first_busy", 32'(busy), 32'd1);

    // Back-to-back handover with no idle cycle
    step(1'b0, 4'b0100);
    chk("b2b_grant", 32'(grant), 32'h4);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b1000);
    chk("to3_grant", 32'(grant), 32'h8);

    // Owner 3 releases while cache 0 waits: the search wraps to 0
    step(1'b0, 4'b1001);
    chk("hold3_grant", 32'(grant), 32'h8);
    step(1'b0, 4'b0001);
    chk("wrap_grant", 32'(grant), 32'h1);
    step(1'b0, 4'b0000);
    chk("idle_grant", 32'(grant), 32'h0);

    // All four request; each one releases after two cycles
    step(1'b1, '0);
    step(1'b0, 4'hF);
    chk("rr_order_0", 32'(grant), 32'h1);
    for (int k = 0; k < N; k++) begin
      step(1'b0, 4'hF);
      r = 4'hF;
      r[k] = 1'b0;
      step(1'b0, r);
      eg = '0;
      eg[(k + 1) % N] = 1'b1;
      chk($sformatf("rr_order_%0d", k + 1), 32'(grant), 32'(eg));
    end

    // Watchdog: a lone owner is never revoked; a waiting competitor forces a revoke
    step(1'b1, '0);
    step(1'b0, 4'b0010);
    chk("wd_grant1", 32'(grant), 32'h2);
    repeat (8) step(1'b0, 4'b0010);
    chk("wd_alone_timeout", 32'(timeout), 32'd0);
    chk("wd_alone_grant", 32'(grant), 32'h2);
    step(1'b0, 4'b0110);
    if (WD) begin
      chk("wd_revoke_grant", 32'(grant), 32'h0);
      chk("wd_revoke_busy", 32'(busy), 32'd0);
      chk("wd_revoke_timeout", 32'(timeout), 32'd1);
    end else begin
      chk("nowd_hold_grant", 32'(grant), 32'h2);
      chk("nowd_timeout", 32'(timeout), 32'd0);
    end
    step(1'b0, 4'b0110);
    if (WD) begin
      chk("wd_next_grant", 32'(grant), 32'h4);
      chk("wd_pulse_end", 32'(timeout), 32'd0);
    end else begin
      chk("nowd_hold_grant2", 32'(grant), 32'h2);
    end

    // Reset in the middle of a grant
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0010);
    chk("pre_rst_grant", 32'(grant), 32'h2);
    step(1'b1, 4'b0010);
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    step(1'b0, 4'b0010);
    chk("post_rst_grant", 32'(grant), 32'h2);
    chk("post_rst_owner", 32'(ownerIndex), 32'd1);

    // Random requests with sticky patterns and occasional resets
    prev = '0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) r = N'($urandom);
      else r = prev;
      prev = r;
      step(rst, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
